// File: rtl/ysyx_lsu_pkg.sv
// Shared constants for the LSU-to-AXI bridge: widths, FSM states,
// AXI response and transfer size encodings.
package ysyx_lsu_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RD_A = 3'd1;
   localparam logic [2:0] S_RD_D = 3'd2;
   localparam logic [2:0] S_WR_A = 3'd3;
   localparam logic [2:0] S_WR_B = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   localparam logic [2:0] SZ_B = 3'd0;
   localparam logic [2:0] SZ_H = 3'd1;
   localparam logic [2:0] SZ_W = 3'd2;

endpackage

// File: rtl/ysyx_lsu_lane_align.sv
// Mask-to-size encode, byte-lane shift of store strobe/data and
// misalignment detection for a single LSU request.
module ysyx_lsu_lane_align
   import ysyx_lsu_pkg::*;
(
   input  logic [7:0]      mask_i,
   input  logic [1:0]      offs_i,
   input  logic [3:0]      strb_i,
   input  logic [XLEN-1:0] data_i,
   output logic [2:0]      size_o,
   output logic [3:0]      strb_o,
   output logic [XLEN-1:0] data_o,
   output logic            misalign_o
);

   always_comb begin
      case (mask_i)
         8'h01:   size_o = SZ_B;
         8'h03:   size_o = SZ_H;
         default: size_o = SZ_W;
      endcase
   end

   assign strb_o = strb_i << offs_i;
   assign data_o = data_i << {offs_i, 3'b000};

   // a halfword may straddle lanes 1-2, but never the word boundary
   assign misalign_o = ((size_o == SZ_H) && (offs_i == 2'd3))
                    || ((size_o == SZ_W) && (offs_i != 2'd0));

endmodule

// File: rtl/ysyx_lsu_axi_bridge.sv
// Converts one held LSU load/store request into an AXI4-Lite style
// transaction and returns a single-cycle completion pulse.
module ysyx_lsu_axi_bridge
   import ysyx_lsu_pkg::*;
(
   input  logic            clock,
   input  logic            reset,
   input  logic [XLEN-1:0] lsu_araddr,
   input  logic            lsu_arvalid,
   input  logic [7:0]      lsu_rstrb,
   output logic [XLEN-1:0] lsu_rdata,
   output logic            lsu_rvalid,
   input  logic [XLEN-1:0] lsu_awaddr,
   input  logic            lsu_awvalid,
   input  logic [XLEN-1:0] lsu_wdata,
   input  logic            lsu_wvalid,
   input  logic [7:0]      lsu_wstrb,
   output logic            lsu_wready,
   output logic [XLEN-1:0] m_araddr,
   output logic [2:0]      m_arsize,
   output logic            m_arvalid,
   input  logic            m_arready,
   input  logic [XLEN-1:0] m_rdata,
   input  logic [1:0]      m_rresp,
   input  logic            m_rvalid,
   output logic            m_rready,
   output logic [XLEN-1:0] m_awaddr,
   output logic [2:0]      m_awsize,
   output logic            m_awvalid,
   input  logic            m_awready,
   output logic [XLEN-1:0] m_wdata,
   output logic [3:0]      m_wstrb,
   output logic            m_wvalid,
   input  logic            m_wready,
   input  logic [1:0]      m_bresp,
   input  logic            m_bvalid,
   output logic            m_bready,
   output logic            err
);

   logic [2:0]      state_q, state_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [2:0]      size_q, size_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [3:0]      wstrb_q, wstrb_d;
   logic [XLEN-1:0] rdata_q, rdata_d;
   logic            err_q, err_d;
   logic            ld_q, ld_d;
   logic            aw_done_q, aw_done_d;
   logic            w_done_q, w_done_d;

   logic [7:0]      al_mask;
   logic [1:0]      al_offs;
   logic [2:0]      al_size;
   logic [3:0]      al_strb;
   logic [XLEN-1:0] al_data;
   logic            al_mis;
   logic            st_req;

   // load has priority, so the aligner looks at the load side whenever it is valid
   assign al_mask = lsu_arvalid ? lsu_rstrb : lsu_wstrb;
   assign al_offs = lsu_arvalid ? lsu_araddr[1:0] : lsu_awaddr[1:0];
   assign st_req  = lsu_awvalid && lsu_wvalid;

   ysyx_lsu_lane_align u_align (
      .mask_i     (al_mask),
      .offs_i     (al_offs),
      .strb_i     (lsu_wstrb[3:0]),
      .data_i     (lsu_wdata),
      .size_o     (al_size),
      .strb_o     (al_strb),
      .data_o     (al_data),
      .misalign_o (al_mis)
   );

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      size_d    = size_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      ld_d      = ld_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      case (state_q)
         S_IDLE: begin
            if (lsu_arvalid || st_req) begin
               ld_d      = lsu_arvalid;
               addr_d    = lsu_arvalid ? lsu_araddr : lsu_awaddr;
               size_d    = al_size;
               rdata_d   = '0;
               err_d     = al_mis;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               if (!lsu_arvalid) begin
                  wdata_d = al_data;
                  wstrb_d = al_strb;
               end
               if (al_mis)           state_d = S_DONE;
               else if (lsu_arvalid) state_d = S_RD_A;
               else                  state_d = S_WR_A;
            end
         end
         S_RD_A: if (m_arready) state_d = S_RD_D;
         S_RD_D: begin
            if (m_rvalid) begin
               rdata_d = m_rdata;
               err_d   = (m_rresp != RESP_OKAY);
               state_d = S_DONE;
            end
         end
         S_WR_A: begin
            aw_done_d = aw_done_q || m_awready;
            w_done_d  = w_done_q || m_wready;
            if (aw_done_d && w_done_d) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = S_WR_B;
            end
         end
         S_WR_B: begin
            if (m_bvalid) begin
               err_d   = (m_bresp != RESP_OKAY);
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         size_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         ld_q      <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         size_q    <= size_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         ld_q      <= ld_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   assign m_araddr  = addr_q;
   assign m_arsize  = size_q;
   assign m_arvalid = (state_q == S_RD_A);
   assign m_rready  = (state_q == S_RD_D);
   assign m_awaddr  = addr_q;
   assign m_awsize  = size_q;
   assign m_awvalid = (state_q == S_WR_A) && !aw_done_q;
   assign m_wdata   = wdata_q;
   assign m_wstrb   = wstrb_q;
   assign m_wvalid  = (state_q == S_WR_A) && !w_done_q;
   assign m_bready  = (state_q == S_WR_B);

   assign lsu_rdata  = rdata_q;
   assign lsu_rvalid = (state_q == S_DONE) && ld_q;
   assign lsu_wready = (state_q == S_DONE) && !ld_q;
   assign err        = (state_q == S_DONE) && err_q;

endmodule

// File: doc/ysyx_lsu_axi_bridge.md
# ysyx_lsu_axi_bridge

Bus-side responder for the load/store unit's request interface. Accepts one level-held LSU load or store request at a time and converts it to an AXI4-Lite-style master transaction with byte-lane alignment. Returns a one-cycle completion pulse with raw word data to the LSU. Sits between the LSU and the data-side crossbar/arbiter.

## Interface
- XLEN, `YSYX_XLEN (32), data/address width
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- lsu_araddr  in  XLEN  load byte address, held while lsu_arvalid
- lsu_arvalid  in  1  load request, level, held until lsu_rvalid seen
- lsu_rstrb  in  8  low-aligned load mask: 8'h1/8'h3/8'hf
- lsu_rdata  out  XLEN  raw aligned word from bus (LSU does lane shift/extension)
- lsu_rvalid  out  1  load completion pulse, exactly one cycle
- lsu_awaddr, lsu_wdata  in  XLEN  store address / low-aligned store data
- lsu_awvalid, lsu_wvalid  in  1  store request, level, asserted together
- lsu_wstrb  in  8  low-aligned store mask, bits [3:0] used
- lsu_wready  out  1  store completion pulse, exactly one cycle
- m_araddr out XLEN; m_arsize out 3; m_arvalid out 1; m_arready in 1
- m_rdata in XLEN; m_rresp in 2; m_rvalid in 1; m_rready out 1
- m_awaddr out XLEN; m_awsize out 3; m_awvalid out 1; m_awready in 1
- m_wdata out XLEN; m_wstrb out 4; m_wvalid out 1; m_wready in 1
- m_bresp in 2; m_bvalid in 1; m_bready out 1
- err  out  1  one-cycle pulse coincident with completion on bus error or misalignment

## Operation
- States: IDLE, RD_A, RD_D, WR_A, WR_B, DONE.
- IDLE: if lsu_arvalid, latch address and size, go RD_A; else if lsu_awvalid&&lsu_wvalid, latch address, shifted data, shifted strobe, size, go WR_A. Load wins if both valid.
- Size: mask 1→0, 3→1, f→2; other masks treated as 2.
- Store lanes: m_wstrb = wstrb[3:0] << addr[1:0]; m_wdata = wdata << 8*addr[1:0]. Addresses passed unmodified.
- Misaligned (halfword at offset 3, word at offset ≠0): no bus transaction; IDLE→DONE directly, completion pulse with err=1, lsu_rdata=0.
- RD_A: m_arvalid=1 until m_arready, then RD_D. RD_D: m_rready=1; on m_rvalid capture m_rdata and rresp, go DONE.
- WR_A: m_awvalid and m_wvalid independent; each drops after its own handshake (aw_done/w_done flags); when both done go WR_B. WR_B: m_bready=1; on m_bvalid capture bresp, go DONE.
- DONE: one cycle; pulse lsu_rvalid (load) or lsu_wready (store); err = resp≠0 or misaligned; requests ignored; unconditional →IDLE.
- One outstanding transaction; no caching, no write buffering.

## Timing
- Reset: state IDLE; all outputs 0 (lsu_rdata, lsu_rvalid, lsu_wready, err, all m_* valid/ready/addr/data/strb/size).
- All outputs registered or decoded from state only; no combinational path from m_* inputs to outputs.
- Minimum load latency: request seen at cycle 0 → m_arvalid cycle 1 → m_rready/rvalid cycle 2 → lsu_rvalid cycle 3.
- Minimum store latency: cycle 0 → aw/w cycle 1 → bvalid cycle 2 → lsu_wready cycle 3.
- Back-to-back: new request accepted in the IDLE cycle following DONE.
- m_*valid held stable with payload until handshake; never withdrawn except on reset.
- Reset mid-transaction: abandon immediately, IDLE next cycle, no completion pulse.

## Structure
- Shared package/header (ysyx.svh): state enum, AXI resp codes (OKAY=0), size codes.
- Sub-module ysyx_lsu_lane_align: combinational mask→size encode, strobe/data lane shift, misalignment detect; used for the store and load paths.
- Top holds FSM, latches, handshake flags; target 150-250 lines.

## Test plan
- LW 0x80000004, arready=1, rvalid 4 cycles later with 0xdeadbeef → m_araddr=0x80000004, m_arsize=2, lsu_rdata=0xdeadbeef, one lsu_rvalid pulse, err=0.
- SB 0x80000003 wdata=0x000000a5 → m_wstrb=4'b1000, m_wdata=0xa5000000, m_awsize=0; lsu_wready pulse one cycle after bvalid.
- SH with awready at cycle 1, wready at cycle 4 → m_awvalid drops after cycle 1, m_wvalid held to cycle 4, bready only after both.
- LW at 0x80000002 → no m_arvalid, lsu_rvalid pulse with err=1, lsu_rdata=0.
- rresp=2'b10 on load → lsu_rvalid and err pulse same cycle; lsu_arvalid held through DONE not re-issued.
- Reset asserted in RD_D → all outputs 0 next cycle, no lsu_rvalid; subsequent load completes normally.
